// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers
// for the convolution job dispatcher.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Index width for a pool of v entries, never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int out_dim(
    input int n,
    input int f,
    input int s,
    input int p
  );
    return (n - f + 2 * p) / s + 1;
  endfunction

  function automatic int total_jobs(
    input int n,
    input int f,
    input int s,
    input int p,
    input int k,
    input int nf
  );
    int o;
    o = out_dim(n, f, s, p);
    return o * o * k * nf;
  endfunction

endpackage

// File: rtl/conv_dispatch_ctrl_prio_enc_free.sv
// Lowest-index free PE finder over the
// occupancy mask.
module prio_enc_free #(
  parameter int NPE = 64,
  parameter int PW  = 6
) (
  input  logic [NPE-1:0] busy,
  output logic [PW-1:0]  idx,
  output logic           any_free
);

  // Scan high to low so the lowest clear bit wins.
  always_comb begin
    idx      = '0;
    any_free = ~&busy;
    for (int i = NPE - 1; i >= 0; i--) begin
      if (!busy[i]) idx = PW'(i);
    end
  end

endmodule

// File: rtl/conv_dispatch_ctrl.sv
// Dispatches one job per output pixel, channel
// and filter onto a pool of PEs.
module conv_dispatch_ctrl
  import conv_pkg::*;
#(
  parameter  int N   = 640,
  parameter  int F   = 3,
  parameter  int S   = 1,
  parameter  int P   = 0,
  parameter  int K   = 3,
  parameter  int NF  = 3,
  parameter  int NPE = 64,
  parameter  int CW  = 16,
  localparam int PW  = clog2(NPE)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           start,
  input  logic [NPE-1:0] pe_done,
  output logic           job_valid,
  input  logic           job_ready,
  output logic [PW-1:0]  job_pe,
  output logic [CW-1:0]  job_row,
  output logic [CW-1:0]  job_col,
  output logic [CW-1:0]  job_ch,
  output logic [CW-1:0]  job_filt,
  output logic [NPE-1:0] pe_busy,
  output logic [31:0]    jobs_issued,
  output logic           layer_done,
  output logic           err_spurious
);

  localparam int OUT   = out_dim(N, F, S, P);
  localparam int TOTAL = total_jobs(N, F, S, P, K, NF);

  localparam logic [CW-1:0] XY_MAX = CW'(OUT - 1);
  localparam logic [CW-1:0] CH_MAX = CW'(K - 1);
  localparam logic [CW-1:0] FL_MAX = CW'(NF - 1);
  localparam logic [31:0]   LAST   = 32'(TOTAL - 1);

  state_e         state_q, state_d;
  logic           job_valid_q, job_valid_d;
  logic [PW-1:0]  job_pe_q, job_pe_d;
  logic [CW-1:0]  job_row_q, job_row_d;
  logic [CW-1:0]  job_col_q, job_col_d;
  logic [CW-1:0]  job_ch_q, job_ch_d;
  logic [CW-1:0]  job_filt_q, job_filt_d;
  logic [NPE-1:0] pe_busy_q, pe_busy_d;
  logic [31:0]    jobs_issued_q, jobs_issued_d;
  logic           layer_done_q, layer_done_d;
  logic           err_spurious_q, err_spurious_d;

  logic           accept;
  logic [NPE-1:0] issue_mask;
  logic           spur;
  logic [PW-1:0]  free_idx;
  logic           any_free;

  // Search runs on next-cycle occupancy so a freed PE is reusable at once.
  prio_enc_free #(
    .NPE (NPE),
    .PW  (PW)
  ) u_enc (
    .busy     (pe_busy_d),
    .idx      (free_idx),
    .any_free (any_free)
  );

  // Next-state, occupancy, coordinate and output computation.
  always_comb begin
    state_d        = state_q;
    job_row_d      = job_row_q;
    job_col_d      = job_col_q;
    job_ch_d       = job_ch_q;
    job_filt_d     = job_filt_q;
    jobs_issued_d  = jobs_issued_q;

    accept     = en && (state_q == ST_DISPATCH) && job_valid_q && job_ready;
    issue_mask = accept ? (NPE'(1) << job_pe_q) : '0;
    // A done on the PE being issued to in the same edge is a collision,
    // not a stray pulse.
    spur       = |(pe_done & ~pe_busy_q & ~issue_mask);
    pe_busy_d  = (pe_busy_q & ~(pe_done & pe_busy_q)) | issue_mask;
    err_spurious_d = err_spurious_q | spur;

    if (accept) begin
      jobs_issued_d = jobs_issued_q + 32'd1;
      if (job_col_q == XY_MAX) begin
        job_col_d = '0;
        if (job_row_q == XY_MAX) begin
          job_row_d = '0;
          if (job_ch_q == CH_MAX) begin
            job_ch_d   = '0;
            job_filt_d = (job_filt_q == FL_MAX) ? '0 : job_filt_q + CW'(1);
          end else begin
            job_ch_d = job_ch_q + CW'(1);
          end
        end else begin
          job_row_d = job_row_q + CW'(1);
        end
      end else begin
        job_col_d = job_col_q + CW'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && en) begin
          state_d        = ST_DISPATCH;
          job_row_d      = '0;
          job_col_d      = '0;
          job_ch_d       = '0;
          job_filt_d     = '0;
          jobs_issued_d  = '0;
          err_spurious_d = spur;
        end
      end
      ST_DISPATCH: begin
        if (accept && (jobs_issued_q == LAST)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pe_busy_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!en) begin
      state_d   = ST_IDLE;
      pe_busy_d = '0;
    end

    job_valid_d  = (state_d == ST_DISPATCH) && any_free;
    job_pe_d     = free_idx;
    if (job_valid_q && !job_ready && (state_d == ST_DISPATCH)) begin
      job_pe_d = job_pe_q;
    end
    layer_done_d = (state_d == ST_DONE);
  end

  // Controller state and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      job_valid_q    <= 1'b0;
      job_pe_q       <= '0;
      job_row_q      <= '0;
      job_col_q      <= '0;
      job_ch_q       <= '0;
      job_filt_q     <= '0;
      pe_busy_q      <= '0;
      jobs_issued_q  <= '0;
      layer_done_q   <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      job_valid_q    <= job_valid_d;
      job_pe_q       <= job_pe_d;
      job_row_q      <= job_row_d;
      job_col_q      <= job_col_d;
      job_ch_q       <= job_ch_d;
      job_filt_q     <= job_filt_d;
      pe_busy_q      <= pe_busy_d;
      jobs_issued_q  <= jobs_issued_d;
      layer_done_q   <= layer_done_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  assign job_valid    = job_valid_q;
  assign job_pe       = job_pe_q;
  assign job_row      = job_row_q;
  assign job_col      = job_col_q;
  assign job_ch       = job_ch_q;
  assign job_filt     = job_filt_q;
  assign pe_busy      = pe_busy_q;
  assign jobs_issued  = jobs_issued_q;
  assign layer_done   = layer_done_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_conv_dispatch_ctrl.sv
// Directed bench for conv_dispatch_ctrl:
// basic layer, stride/pad, exhaustion, backpressure, abort.
module tb_conv_dispatch_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: N=5 F=3 S=1 P=0 K=1 NF=1 NPE=4
  logic        a_en, a_start, a_ready;
  logic [3:0]  a_pe_done;
  logic        a_valid;
  logic [1:0]  a_pe;
  logic [15:0] a_row, a_col, a_ch, a_filt;
  logic [3:0]  a_busy;
  logic [31:0] a_issued;
  logic        a_ld, a_err;

  // Instance B: N=6 F=3 S=2 P=1 K=2 NF=2 NPE=2
  logic        b_en, b_start, b_ready;
  logic [1:0]  b_pe_done;
  logic        b_valid;
  logic [0:0]  b_pe;
  logic [15:0] b_row, b_col, b_ch, b_filt;
  logic [1:0]  b_busy;
  logic [31:0] b_issued;
  logic        b_ld, b_err;

  conv_dispatch_ctrl #(
    .N(5), .F(3), .S(1), .P(0), .K(1), .NF(1), .NPE(4), .CW(16)
  ) u_a (
    .clk(clk), .rstn(rstn), .en(a_en), .start(a_start),
    .pe_done(a_pe_done), .job_valid(a_valid), .job_ready(a_ready),
    .job_pe(a_pe), .job_row(a_row), .job_col(a_col), .job_ch(a_ch),
    .job_filt(a_filt), .pe_busy(a_busy), .jobs_issued(a_issued),
    .layer_done(a_ld), .err_spurious(a_err)
  );

  conv_dispatch_ctrl #(
    .N(6), .F(3), .S(2), .P(1), .K(2), .NF(2), .NPE(2), .CW(16)
  ) u_b (
    .clk(clk), .rstn(rstn), .en(b_en), .start(b_start),
    .pe_done(b_pe_done), .job_valid(b_valid), .job_ready(b_ready),
    .job_pe(b_pe), .job_row(b_row), .job_col(b_col), .job_ch(b_ch),
    .job_filt(b_filt), .pe_busy(b_busy), .jobs_issued(b_issued),
    .layer_done(b_ld), .err_spurious(b_err)
  );

  typedef struct {
    int pe;
    int row;
    int col;
  } vec_t;

  vec_t tbl[9];
  int   tmr_a[4];
  int   tmr_b[2];
  int   k;
  int   nld;
  int   w;
  logic [63:0] snap;
  logic [1:0]  snap_pe;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected B coordinates for job index j: col, row, ch, filt order.
  task automatic chk_b(input int j);
    logic [63:0] e;
    e = {16'((j / 3) % 3), 16'(j % 3), 16'((j / 9) % 2), 16'(j / 18)};
    if (j < 36)
      chk($sformatf("b_job%0d", j), {b_row, b_col, b_ch, b_filt}, e);
    else
      chk("b_extra_job", 64'(j), 64'(35));
  endtask

  initial begin
    tbl[0] = '{0, 0, 0};
    tbl[1] = '{1, 0, 1};
    tbl[2] = '{2, 0, 2};
    tbl[3] = '{3, 1, 0};
    tbl[4] = '{0, 1, 1};
    tbl[5] = '{1, 1, 2};
    tbl[6] = '{2, 2, 0};
    tbl[7] = '{3, 2, 1};
    tbl[8] = '{0, 2, 2};

    a_en = 0; a_start = 0; a_ready = 0; a_pe_done = '0;
    b_en = 0; b_start = 0; b_ready = 0; b_pe_done = '0;
    for (int p = 0; p < 4; p++) tmr_a[p] = 0;
    for (int p = 0; p < 2; p++) tmr_b[p] = 0;

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(a_valid), 64'(0));
    chk("rst_busy", 64'(a_busy), 64'(0));
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_fields", {a_row, a_col, a_ch, a_filt}, 64'(0));
    chk("rst_pe", 64'(a_pe), 64'(0));
    chk("rst_issued", 64'(a_issued), 64'(0));
    chk("rst_ld", 64'(a_ld), 64'(0));
    chk("rst_err", 64'(a_err), 64'(0));
    chk("rst_b_valid", 64'(b_valid), 64'(0));

    // Basic layer, PEs answer 3 cycles after issue.
    a_en = 1; a_ready = 1; a_start = 1;
    @(negedge clk);
    a_start = 0;
    k = 0; nld = 0;
    for (int c = 0; c < 40; c++) begin
      if (a_ld) nld++;
      a_pe_done = '0;
      for (int p = 0; p < 4; p++) begin
        if (tmr_a[p] > 0) begin
          tmr_a[p]--;
          if (tmr_a[p] == 0) a_pe_done[p] = 1'b1;
        end
      end
      if (a_valid && a_ready) begin
        if (k < 9) begin
          chk($sformatf("a_pe%0d", k), 64'(a_pe), 64'(tbl[k].pe));
          chk($sformatf("a_rc%0d", k), {32'(a_row), 32'(a_col)},
              {32'(tbl[k].row), 32'(tbl[k].col)});
        end else begin
          chk("a_extra_job", 64'(k), 64'(8));
        end
        tmr_a[a_pe] = 3;
        k++;
      end
      @(negedge clk);
    end
    a_pe_done = '0;
    chk("a_jobs_seen", 64'(k), 64'(9));
    chk("a_issued", 64'(a_issued), 64'(9));
    chk("a_layer_done_cnt", 64'(nld), 64'(1));
    chk("a_busy_end", 64'(a_busy), 64'(0));
    chk("a_err_end", 64'(a_err), 64'(0));

    // Backpressure: offer held with ready low.
    a_ready = 0; a_start = 1;
    @(negedge clk);
    a_start = 0;
    w = 0;
    while (!a_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("bp_valid", 64'(a_valid), 64'(1));
    snap = {a_row, a_col, a_ch, a_filt};
    snap_pe = a_pe;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_fields", {a_row, a_col, a_ch, a_filt}, snap);
      chk("bp_pe", 64'(a_pe), 64'(snap_pe));
      chk("bp_valid_hold", 64'(a_valid), 64'(1));
      chk("bp_issued", 64'(a_issued), 64'(0));
    end

    // Collision: done on PE0 in the edge that issues to PE0.
    a_ready = 1; a_pe_done = 4'b0001;
    @(negedge clk);
    a_pe_done = '0;
    chk("coll_busy", 64'(a_busy), 64'(1));
    chk("coll_err", 64'(a_err), 64'(0));
    chk("coll_issued", 64'(a_issued), 64'(1));
    repeat (3) @(negedge clk);
    a_ready = 0;
    chk("full_issued", 64'(a_issued), 64'(4));
    chk("full_busy", 64'(a_busy), 64'(15));
    chk("full_valid", 64'(a_valid), 64'(0));

    // Abort at job 4, then a stray done on idle PE3.
    a_en = 0;
    @(negedge clk);
    chk("abort_valid", 64'(a_valid), 64'(0));
    chk("abort_busy", 64'(a_busy), 64'(0));
    chk("abort_issued", 64'(a_issued), 64'(4));
    a_pe_done = 4'b1000;
    @(negedge clk);
    a_pe_done = '0;
    chk("spur_set", 64'(a_err), 64'(1));
    repeat (3) @(negedge clk);
    chk("spur_sticky", 64'(a_err), 64'(1));
    chk("abort_no_ld", 64'(a_ld), 64'(0));
    a_en = 1; a_start = 1;
    @(negedge clk);
    a_start = 0;
    chk("spur_clear", 64'(a_err), 64'(0));
    chk("restart_issued", 64'(a_issued), 64'(0));
    a_en = 0;

    // Stride/pad layer on a 2-PE pool; first exhaust the pool.
    b_en = 1; b_ready = 1; b_start = 1;
    @(negedge clk);
    b_start = 0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (b_valid && b_ready) begin
        chk_b(k);
        k++;
      end
      @(negedge clk);
    end
    chk("ex_accepts", 64'(k), 64'(2));
    chk("ex_valid", 64'(b_valid), 64'(0));
    chk("ex_busy", 64'(b_busy), 64'(3));
    b_pe_done = 2'b10;
    @(negedge clk);
    b_pe_done = '0;
    chk("ex_reuse_pe", 64'(b_pe), 64'(1));
    chk("ex_reuse_valid", 64'(b_valid), 64'(1));
    chk("ex_reuse_busy", 64'(b_busy), 64'(1));

    tmr_b[0] = 1; tmr_b[1] = 0; nld = 0;
    for (int c = 0; c < 150; c++) begin
      if (b_ld) nld++;
      b_pe_done = '0;
      for (int p = 0; p < 2; p++) begin
        if (tmr_b[p] > 0) begin
          tmr_b[p]--;
          if (tmr_b[p] == 0) b_pe_done[p] = 1'b1;
        end
      end
      if (b_valid && b_ready) begin
        chk_b(k);
        tmr_b[b_pe] = 3;
        k++;
      end
      @(negedge clk);
    end
    b_pe_done = '0;
    chk("b_jobs_seen", 64'(k), 64'(36));
    chk("b_issued", 64'(b_issued), 64'(36));
    chk("b_layer_done_cnt", 64'(nld), 64'(1));
    chk("b_busy_end", 64'(b_busy), 64'(0));
    chk("b_err_end", 64'(b_err), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
